// File: rtl/sonar_trigger_fsm.sv
// rtl/sonar_trigger_fsm.sv - sonar trigger/echo-gate sequencer; optional echo filter via ECHO_DEGLITCH_EN
module sonar_trigger_fsm #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int CNT_W          = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic echo,
    output logic trig,
    output logic gate,
    output logic done,
    output logic timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] per, per_d;
    logic             echo_m, echo_q, echo_s, echo_prev;
    logic             echo_rise, echo_fall;
    logic             trig_d, gate_d, done_d, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m    <= 1'b0;
            echo_q    <= 1'b0;
        end else begin
            echo_m    <= echo;
            echo_q    <= echo_m;
        end
    end

`ifdef ECHO_DEGLITCH_EN
    // Output follows the synchronized level only once it has held for four samples.
    logic [2:0] hist;
    logic       echo_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist   <= 3'b000;
            echo_f <= 1'b0;
        end else begin
            hist   <= {hist[1:0], echo_q};
            echo_f <= echo_s;
        end
    end

    assign echo_s = (hist == {3{echo_q}}) ? echo_q : echo_f;
`else
    assign echo_s = echo_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_prev <= 1'b0;
        end else begin
            echo_prev <= echo_s;
        end
    end

    assign echo_rise = echo_s & ~echo_prev;
    assign echo_fall = ~echo_s & echo_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            per   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            per   <= per_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CNT_ONE;
        per_d   = (per == PER_LAST) ? per : per + CNT_ONE;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end
            end
            WAIT_ECHO: begin
                // A rise seen on the final wait cycle still starts a measurement.
                if (echo_rise) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end else if (cnt == TO_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                if (echo_fall || (cnt == TO_LAST)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (per == PER_LAST) begin
                    state_d = enable ? TRIG : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_d == TRIG) && (state != TRIG)) begin
            per_d = '0;
        end
    end

    always_comb begin
        trig_d    = (state_d == TRIG);
        gate_d    = (state_d == MEASURE);
        done_d    = (state == MEASURE) && echo_fall;
        timeout_d = timeout;
        if ((state == WAIT_ECHO) && (state_d == HOLD)) begin
            timeout_d = 1'b1;
        end
        // A falling edge on the timeout cycle counts as a valid measurement.
        if ((state == MEASURE) && (state_d == HOLD)) begin
            timeout_d = ~echo_fall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig    <= 1'b0;
            gate    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            trig    <= trig_d;
            gate    <= gate_d;
            done    <= done_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sonar_trigger_fsm.sv
// tb/tb_sonar_trigger_fsm.sv - vector-table bench for sonar_trigger_fsm
`timescale 1ns/1ps
module tb_sonar_trigger_fsm;

    localparam int TRIG_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int PERIOD_CYCLES  = 100;
    localparam int CNT_W          = 8;
`ifdef ECHO_DEGLITCH_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic echo;
    logic trig, gate, done, timeout;

    int errors = 0;
    int checks = 0;

    sonar_trigger_fsm #(
        .TRIG_CYCLES    (TRIG_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PERIOD_CYCLES  (PERIOD_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .echo    (echo),
        .trig    (trig),
        .gate    (gate),
        .done    (done),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dly;
        int len;
        int glitch;
        int drop_en;
        int exp_trig_w;
        int exp_lat;
        int exp_gate_w;
        int exp_done;
        int exp_tout;
        int exp_to_at;
        int exp_period;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int dly, input int len, input int glitch, input int drop_en,
                                input int lat, input int gw, input int dn, input int tout,
                                input int to_at, input int period);
        vec_t v;
        v.dly = dly; v.len = len; v.glitch = glitch; v.drop_en = drop_en;
        v.exp_trig_w = TRIG_CYCLES; v.exp_lat = lat; v.exp_gate_w = gw;
        v.exp_done = dn; v.exp_tout = tout; v.exp_to_at = to_at; v.exp_period = period;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Echo window is indexed by cycles since the first trig sample after reset release.
    task automatic run_vec(input vec_t v, output int trig_w, output int lat, output int gate_w,
                           output int ndone, output int tout, output int to_at,
                           output int period, output int overlap);
        int  fr, sr, gr;
        bit  ptrig, pgate, win;
        rst = 1'b1; enable = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        fr = -1; sr = -1; gr = -1;
        trig_w = 0; gate_w = 0; ndone = 0; to_at = -1; overlap = 0; tout = 0;
        ptrig = 1'b0; pgate = 1'b0;
        for (int n = 0; n < 300 && sr < 0; n++) begin
            @(negedge clk);
            if (trig && !ptrig) begin
                if (fr < 0) fr = n;
                else        sr = n;
            end
            if (sr < 0) begin
                if (trig) trig_w++;
                if (gate) gate_w++;
                if (gate && !pgate && gr < 0) gr = n;
                if (done) ndone++;
                if (timeout && to_at < 0) to_at = n;
                if (trig && gate) overlap = 1;
            end
            tout  = timeout ? 1 : 0;
            ptrig = trig;
            pgate = gate;
            win = (n >= v.dly) && (n < v.dly + v.len);
            if (v.glitch != 0 && n >= v.dly - 8 && n < v.dly - 5) win = 1'b1;
            echo = win;
            if (v.drop_en != 0 && n == 2) enable = 1'b0;
        end
        lat    = (gr < 0) ? -1 : gr - v.dly;
        period = (sr < 0 || fr < 0) ? -1 : sr - fr;
        echo   = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tw, lat, gw, nd, to, ta, per, ov, cnt;
        bit seen;

        vq.push_back(mk(14,           20, 0, 0, LAT, 20, 1, 0, -1,             100));
        vq.push_back(mk(0,             0, 0, 0, -1,   0, 0, 1, 54,             100));
        vq.push_back(mk(9,            80, 0, 0, LAT, 50, 0, 1, 9 + LAT + 50,   100));
        vq.push_back(mk(9,            50, 0, 0, LAT, 50, 1, 0, -1,             100));
        vq.push_back(mk(9,            51, 0, 0, LAT, 50, 0, 1, 9 + LAT + 50,   100));
        vq.push_back(mk(8,             4, 0, 0, LAT,  4, 1, 0, -1,             100));
        vq.push_back(mk(54 - LAT,     10, 0, 0, LAT, 10, 1, 0, -1,             100));
        vq.push_back(mk(55 - LAT,     10, 0, 0, -1,   0, 0, 1, 54,             100));
        vq.push_back(mk(14,           20, 0, 1, LAT, 20, 1, 0, -1,             -1));
`ifdef ECHO_DEGLITCH_EN
        vq.push_back(mk(14,           20, 1, 0, LAT, 20, 1, 0, -1,             100));
`else
        vq.push_back(mk(0,            20, 0, 0, -1,   0, 0, 1, 54,             100));
`endif

        rst = 1'b1; enable = 1'b1; echo = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.trig",    int'(trig),    0);
        check("reset.gate",    int'(gate),    0);
        check("reset.done",    int'(done),    0);
        check("reset.timeout", int'(timeout), 0);

        foreach (vq[i]) begin
            run_vec(vq[i], tw, lat, gw, nd, to, ta, per, ov);
            check($sformatf("v%0d.trig_w",  i), tw,  vq[i].exp_trig_w);
            check($sformatf("v%0d.latency", i), lat, vq[i].exp_lat);
            check($sformatf("v%0d.gate_w",  i), gw,  vq[i].exp_gate_w);
            check($sformatf("v%0d.done_n",  i), nd,  vq[i].exp_done);
            check($sformatf("v%0d.timeout", i), to,  vq[i].exp_tout);
            check($sformatf("v%0d.to_at",   i), ta,  vq[i].exp_to_at);
            check($sformatf("v%0d.period",  i), per, vq[i].exp_period);
            check($sformatf("v%0d.overlap", i), ov,  0);
        end

        // Asynchronous reset in the middle of a measurement, then resume.
        rst = 1'b1; enable = 1'b0; echo = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (gate) seen = 1'b1;
            echo = (n >= 14);
        end
        check("rstmid.gate_seen", int'(seen), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid.gate_async", int'(gate), 0);
        check("rstmid.done_async", int'(done), 0);
        @(negedge clk);
        check("rstmid.done_held", int'(done), 0);
        check("rstmid.trig_held", int'(trig), 0);
        echo = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        check("rstmid.trig_resume", int'(trig), 1);
        cnt = 1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (trig) cnt++;
            if (done) cnt = cnt + 100;
        end
        check("rstmid.trig_w", cnt, TRIG_CYCLES);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
